// File: rtl/serial_addsub_unit.sv
// ============================================================================
// Module   : serial_addsub_unit
// Brief    : Digit-serial WIDTH-bit ADD/SUB/ADC/SBC unit with N/Z/C/V flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int c_CYCLES = WIDTH / DIGIT;
    localparam int c_CW     = (c_CYCLES > 1) ? $clog2(c_CYCLES) : 1;
    localparam int c_BW     = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_CYCLES - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_work;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_dsum;
    logic             w_cmsb;
    logic [c_BW-1:0]  w_base;
    logic [WIDTH-1:0] w_work_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = (r_state == c_RUN);
        w_accept = (r_state == c_IDLE) && start;
        w_last   = (r_state == c_RUN) && (r_cnt == c_LAST);
    end

    // Operands shift right so the active digit always sits in the low bits.
    always_comb begin
        w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_c);
        // carry into the digit MSB recovered from sum and operand MSBs
        w_cmsb = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
        w_base = c_BW'(r_cnt) * c_BW'(DIGIT);
        w_work_next = r_work;
        w_work_next[w_base +: DIGIT] = w_dsum[DIGIT-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_work <= '0;
            result <= '0;
            flags  <= 4'b0000;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= op[0] ? ~b : b;
                r_c   <= op[1] ? cin : op[0];
                r_cnt <= '0;
            end else if (busy) begin
                r_a    <= r_a >> DIGIT;
                r_b    <= r_b >> DIGIT;
                r_c    <= w_dsum[DIGIT];
                r_work <= w_work_next;
                if (w_last) begin
                    r_cnt  <= '0;
                    result <= w_work_next;
                    flags  <= {w_cmsb ^ w_dsum[DIGIT],
                               w_dsum[DIGIT],
                               (w_work_next == '0),
                               w_work_next[WIDTH-1]};
                    done   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
// ============================================================================
// Module   : tb_serial_addsub_unit
// Brief    : Directed-vector bench over four WIDTH/DIGIT configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub_unit;

    typedef struct {
        logic [1:0]  op;
        logic        cin;
        logic [7:0]  a8;
        logic [7:0]  b8;
        logic [7:0]  r8;
        logic [3:0]  f8;
        logic [15:0] a16;
        logic [15:0] b16;
        logic [15:0] r16;
        logic [3:0]  f16;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start = 4'b0000;
    logic [1:0]  op = 2'b00;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy0, busy1, busy2, busy3;
    logic        done0, done1, done2, done3;
    logic [7:0]  res0, res1, res2;
    logic [15:0] res3;
    logic [3:0]  fl0, fl1, fl2, fl3;

    int n_checks = 0;
    int n_bad    = 0;
    vec_t tv[10];
    int cyc_tab[4] = '{4, 8, 1, 4};

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(8),  .DIGIT(2)) u_w8d2 (
        .clk(clk), .rst(rst), .start(start[0]), .op(op), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy0), .done(done0), .result(res0), .flags(fl0));
    serial_addsub_unit #(.WIDTH(8),  .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start[1]), .op(op), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy1), .done(done1), .result(res1), .flags(fl1));
    serial_addsub_unit #(.WIDTH(8),  .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst(rst), .start(start[2]), .op(op), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .busy(busy2), .done(done2), .result(res2), .flags(fl2));
    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst(rst), .start(start[3]), .op(op), .cin(cin),
        .a(a), .b(b), .busy(busy3), .done(done3), .result(res3), .flags(fl3));

    function automatic logic get_busy(int i);
        case (i)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic logic get_done(int i);
        case (i)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    function automatic logic [15:0] get_res(int i);
        case (i)
            0: return {8'h00, res0};
            1: return {8'h00, res1};
            2: return {8'h00, res2};
            default: return res3;
        endcase
    endfunction

    function automatic logic [3:0] get_fl(int i);
        case (i)
            0: return fl0;
            1: return fl1;
            2: return fl2;
            default: return fl3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives vector v into config i; returns just after the accepting edge.
    task automatic issue(input int i, input int v);
        op  = tv[v].op;
        cin = tv[v].cin;
        a   = (i == 3) ? tv[v].a16 : {8'h00, tv[v].a8};
        b   = (i == 3) ? tv[v].b16 : {8'h00, tv[v].b8};
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        op  = 2'($urandom);
        cin = 1'($urandom);
        check($sformatf("cfg%0d v%0d busy_after_accept", i, v), int'(get_busy(i)), 1);
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (get_busy(i) && get_done(i))
                check($sformatf("cfg%0d busy_and_done", i), 1, 0);
            if (get_done(i)) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input int i, input int v, input string tag);
        int er, ef;
        er = (i == 3) ? int'(tv[v].r16) : int'(tv[v].r8);
        ef = (i == 3) ? int'(tv[v].f16) : int'(tv[v].f8);
        check($sformatf("cfg%0d %s v%0d result", i, tag, v), int'(get_res(i)), er);
        check($sformatf("cfg%0d %s v%0d flags", i, tag, v), int'(get_fl(i)), ef);
    endtask

    initial begin
        int lat;
        int seen;
        //          op     cin   a8     b8     r8     f8       a16       b16       r16       f16
        tv[0] = '{2'b00, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b1001, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
        tv[1] = '{2'b00, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b0110, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
        tv[2] = '{2'b01, 1'b0, 8'h05, 8'h05, 8'h00, 4'b0110, 16'h0005, 16'h0005, 16'h0000, 4'b0110};
        tv[3] = '{2'b01, 1'b0, 8'h00, 8'h01, 8'hFF, 4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 4'b0001};
        tv[4] = '{2'b01, 1'b0, 8'h80, 8'h01, 8'h7F, 4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
        tv[5] = '{2'b10, 1'b1, 8'hFE, 8'h01, 8'h00, 4'b0110, 16'hFFFE, 16'h0001, 16'h0000, 4'b0110};
        tv[6] = '{2'b11, 1'b0, 8'h10, 8'h01, 8'h0E, 4'b0100, 16'h0010, 16'h0001, 16'h000E, 4'b0100};
        tv[7] = '{2'b00, 1'b1, 8'h3A, 8'h25, 8'h5F, 4'b0000, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
        tv[8] = '{2'b10, 1'b0, 8'h01, 8'h01, 8'h02, 4'b0000, 16'h0001, 16'h0001, 16'h0002, 4'b0000};
        tv[9] = '{2'b11, 1'b1, 8'h05, 8'h03, 8'h02, 4'b0100, 16'h0005, 16'h0003, 16'h0002, 4'b0100};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cfg%0d reset busy", i), int'(get_busy(i)), 0);
            check($sformatf("cfg%0d reset done", i), int'(get_done(i)), 0);
            check($sformatf("cfg%0d reset result", i), int'(get_res(i)), 0);
            check($sformatf("cfg%0d reset flags", i), int'(get_fl(i)), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            // Table vectors; v1 is followed back-to-back by v2 in its done cycle.
            for (int v = 0; v < 10; v++) begin
                issue(i, v);
                wait_done(i, lat);
                check($sformatf("cfg%0d v%0d latency", i, v), lat, cyc_tab[i]);
                check_result(i, v, "vec");
                if (v != 1) begin
                    @(posedge clk); #1;
                    check($sformatf("cfg%0d v%0d done_one_cycle", i, v), int'(get_done(i)), 0);
                    check($sformatf("cfg%0d v%0d idle_busy", i, v), int'(get_busy(i)), 0);
                end
            end

            // Stray start mid-run must be ignored.
            if (cyc_tab[i] >= 3) begin
                issue(i, 0);
                @(posedge clk); #1;
                start[i] = 1'b1;
                a  = 16'h5A5A;
                b  = 16'h1111;
                op = 2'b01;
                @(posedge clk); #1;
                start[i] = 1'b0;
                wait_done(i, lat);
                check($sformatf("cfg%0d ignore latency", i), lat + 2, cyc_tab[i]);
                check_result(i, 0, "ignore");
                @(posedge clk); #1;
                check($sformatf("cfg%0d ignore no_queue", i), int'(get_busy(i)), 0);
            end

            // Reset two cycles into RUN aborts without done.
            if (cyc_tab[i] >= 3) begin
                issue(i, 1);
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                check($sformatf("cfg%0d abort busy", i), int'(get_busy(i)), 0);
                check($sformatf("cfg%0d abort done", i), int'(get_done(i)), 0);
                check($sformatf("cfg%0d abort result", i), int'(get_res(i)), 0);
                check($sformatf("cfg%0d abort flags", i), int'(get_fl(i)), 0);
                @(posedge clk); #1;
                rst = 1'b0;
                seen = 0;
                for (int n = 0; n < cyc_tab[i] + 2; n++) begin
                    @(posedge clk); #1;
                    if (get_done(i) || get_busy(i)) seen++;
                end
                check($sformatf("cfg%0d abort no_done", i), seen, 0);
                issue(i, 7);
                wait_done(i, lat);
                check($sformatf("cfg%0d post_abort latency", i), lat, cyc_tab[i]);
                check_result(i, 7, "post_abort");
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
